// File: rtl/alu_if.sv
// Operand/result bundle for the multiply-accumulate block.
// The master drives operand pairs; the slave (alu) returns the running sum.
interface alu_if;
    logic [15:0] X;
    logic [15:0] B;
    logic        valid_in;
    logic [38:0] y;

    modport master (output X, output B, output valid_in, input y);
    modport slave  (input X, input B, input valid_in, output y);
endinterface

// File: rtl/alu.sv
// Three-stage unsigned multiply-accumulate: operand register, 32-bit product
// register, 39-bit wrapping accumulator. y is the accumulator register itself.
module alu (
    input  logic  clk,
    input  logic  R,
    alu_if.slave  bus
);
    logic [15:0] r_x_q;
    logic [15:0] r_b_q;
    logic        r_v1;
    logic [31:0] r_p;
    logic        r_v2;
    logic [38:0] r_acc;
    logic [31:0] w_prod;

    assign w_prod = r_x_q * r_b_q;
    assign bus.y  = r_acc;

    // Operands load only on accepted edges; the product stage runs every
    // cycle and the valid bit alone decides whether it is accumulated.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_x_q <= '0;
            r_b_q <= '0;
            r_v1  <= 1'b0;
            r_p   <= '0;
            r_v2  <= 1'b0;
            r_acc <= '0;
        end else begin
            if (bus.valid_in) begin
                r_x_q <= bus.X;
                r_b_q <= bus.B;
            end
            r_v1 <= bus.valid_in;
            r_p  <= w_prod;
            r_v2 <= r_v1;
            if (r_v2)
                r_acc <= r_acc + {7'd0, r_p};
        end
    end
endmodule

// File: tb/tb_alu.sv
// Directed bench for the multiply-accumulate block: a vector table for the
// streaming cases plus hand-written bubble, async-reset and wrap sequences.
module tb_alu;
    logic clk;
    logic R;
    alu_if bus ();

    alu dut (.clk(clk), .R(R), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    typedef struct {
        logic        v;
        logic [15:0] x;
        logic [15:0] b;
        logic [38:0] exp_y;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [38:0] exp_y);
        total++;
        if (bus.y !== exp_y) begin
            bad++;
            $display("FAIL %s: y=%0d expected=%0d", name, bus.y, exp_y);
        end
    endtask

    // Inputs are changed at the falling edge; y is sampled at the next falling edge.
    task automatic step(input logic v, input logic [15:0] x, input logic [15:0] b);
        bus.valid_in = v;
        bus.X        = x;
        bus.B        = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.valid_in = 1'b0;
        bus.X        = '0;
        bus.B        = '0;
        R            = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_y", 39'd0);
        R = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        R     = 1'b1;
        bus.valid_in = 1'b0;
        bus.X = '0;
        bus.B = '0;
        @(negedge clk);

        // exp_y is y after the edge on which this row is applied
        tbl[0]  = '{1'b1, 16'd2,      16'd3,      39'd0};
        tbl[1]  = '{1'b1, 16'd5,      16'd4,      39'd0};
        tbl[2]  = '{1'b1, 16'd1,      16'd1,      39'd6};
        tbl[3]  = '{1'b1, 16'd16,     16'd3,      39'd26};
        tbl[4]  = '{1'b0, 16'd0,      16'd0,      39'd27};
        tbl[5]  = '{1'b0, 16'd0,      16'd0,      39'd75};
        tbl[6]  = '{1'b0, 16'd0,      16'd0,      39'd75};
        tbl[7]  = '{1'b0, 16'd0,      16'd0,      39'd75};
        tbl[8]  = '{1'b1, 16'd0,      16'hFFFF,   39'd75};
        tbl[9]  = '{1'b1, 16'hFFFF,   16'd0,      39'd75};
        tbl[10] = '{1'b0, 16'd0,      16'd0,      39'd75};
        tbl[11] = '{1'b0, 16'd0,      16'd0,      39'd75};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].v)
                step(1'b1, tbl[i].x, tbl[i].b);
            else
                step(1'b0, 16'($urandom), 16'($urandom));
            check($sformatf("vec%0d", i), tbl[i].exp_y);
        end

        // Bubble between two accepted pairs
        do_reset();
        step(1'b1, 16'd2, 16'd3);  check("bub_e1", 39'd0);
        step(1'b0, 16'd9, 16'd9);  check("bub_e2", 39'd0);
        step(1'b1, 16'd5, 16'd4);  check("bub_e3", 39'd6);
        step(1'b0, 16'd7, 16'd7);  check("bub_e4", 39'd6);
        step(1'b0, 16'd7, 16'd7);  check("bub_e5", 39'd26);

        // Async reset with two pairs in flight and y=75
        do_reset();
        step(1'b1, 16'd2,  16'd3);
        step(1'b1, 16'd5,  16'd4);
        step(1'b1, 16'd1,  16'd1);
        step(1'b1, 16'd16, 16'd3);
        step(1'b1, 16'd7,  16'd7);
        step(1'b1, 16'd9,  16'd9);
        check("pre_rst_y", 39'd75);
        bus.valid_in = 1'b0;
        #2 R = 1'b0;
        #1 check("async_rst_y", 39'd0);
        @(negedge clk);
        R = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'($urandom), 16'($urandom));
            check($sformatf("post_rst%0d", i), 39'd0);
        end

        // 128 maximal products fill without wrap; one more wraps mod 2^39
        do_reset();
        for (int i = 0; i < 128; i++)
            step(1'b1, 16'hFFFF, 16'hFFFF);
        step(1'b0, 16'd0, 16'd0);
        step(1'b0, 16'd0, 16'd0);
        check("max128", 39'd549739036800);
        step(1'b1, 16'hFFFF, 16'hFFFF);
        step(1'b0, 16'd0, 16'd0);
        check("wrap_lat1", 39'd549739036800);
        step(1'b0, 16'd0, 16'd0);
        check("wrap", 39'd4278059137);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
